cpu_state_ctrl: RTL and testbench
=================================

# cpu_state_ctrl

Multicycle sequencer for the MIPS CPU core. It generates the one-hot `fetch`/`exec1`/`exec2` phase strobes that drive instruction decode, the register file and memory. It stalls those phases on Avalon `waitrequest` and on the multi-cycle divider. It halts the core when the datapath reports the end-of-program jump, and it keeps cycle and retired-instruction counters for the testbench.

## Interface
Parameters:
- `DIV_MAX_CYCLES`, default 64: cycles allowed in DIV_WAIT before a divider timeout fault; legal range 2..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `waitrequest` in 1: memory bus stall, shared by instruction and data access.
- `instr_code` in 7: decoded instruction code from the decoder; valid during exec1/exec2. DIV=7, DIVU=8, memory ops=42,43,44,45,47,48,49,50,51,52 (LUI=46 is not a memory op).
- `div_done` in 1: divider result ready.
- `halt_req` in 1: datapath signals a jump to address 0.
- `fetch` out 1: instruction fetch phase.
- `exec1` out 1: first execute phase.
- `exec2` out 1: second execute/writeback phase.
- `div_start` out 1: single-cycle divider start pulse.
- `active` out 1: core running; low once halted.
- `fault` out 1: sticky divider-timeout flag.
- `cycle_count` out 32: cycles spent with `active`=1.
- `instr_count` out 32: retired instructions.

## Operation
States: FETCH, EXEC1, DIV_WAIT, EXEC2, HALT. Encoding is free.

Outputs are Moore-decoded from state and registers.
- FETCH → `fetch`=1; EXEC1 → `exec1`=1; EXEC2 → `exec2`=1.
- DIV_WAIT and HALT → all three phase strobes 0.
- `active`=0 only in HALT.

Transitions:
- FETCH: `waitrequest`=1 → stay; else → EXEC1.
- EXEC1:
  - `instr_code` ∈ {7,8} → DIV_WAIT.
  - Else, memory op with `waitrequest`=1 → stay.
  - Else → EXEC2.
  - The divide check takes priority over `waitrequest`.
- DIV_WAIT: an 8-bit `div_cnt` clears on entry and increments each cycle in the state.
  - `div_start`=1 only when `div_cnt`=0.
  - `div_done` is ignored when `div_cnt`=0.
  - `div_done`=1 with `div_cnt`≥1 → EXEC2.
  - Else `div_cnt`=DIV_MAX_CYCLES-1 → HALT and set `fault`.
  - If `div_done` arrives on the timeout cycle, `div_done` wins.
- EXEC2:
  - `instr_count` += 1.
  - `halt_req`=1 → HALT; else → FETCH.
  - `halt_req` is sampled only in EXEC2.
- HALT: absorbing; leaves only via `reset`.

Counters:
- `cycle_count` += 1 on every clock edge taken while in a non-HALT state.
- Both counters wrap modulo 2^32 with no saturation.
- Neither counter increments in HALT.

## Timing
- Reset values (asserted asynchronously): state FETCH, `fetch`=1, `exec1`=0, `exec2`=0, `div_start`=0, `active`=1, `fault`=0, `div_cnt`=0, `cycle_count`=0, `instr_count`=0.
- Reset mid-instruction or mid-divide: immediate return to FETCH with all counters cleared. No state survives.
- Unstalled instruction: exactly 3 cycles (FETCH, EXEC1, EXEC2). Throughput is 1 instruction per 3 cycles.
- Each cycle of `waitrequest`=1 in FETCH, or in EXEC1 for a memory op, adds one cycle.
- Divide latency: 2 + k + 1 cycles, where `div_done` first rises k cycles after `div_start` (k≥1).
- Phase strobes are mutually exclusive in every cycle. At most one is high.
- `exec1` stays high across a stall, so the decoder re-captures the same instruction. This is harmless.

## Test plan
- Reset then `waitrequest`=0, `instr_code`=4 (ADDU) repeated.
  - Required: strobes cycle FETCH, EXEC1, EXEC2 with period 3.
  - After 9 cycles: `instr_count`=3, `cycle_count`=9.
- FETCH with `waitrequest` held for 2 cycles.
  - Required: `fetch` high for 3 cycles, then `exec1`.
  - Repeat with `instr_code`=47 (LW) and `waitrequest` high 1 cycle in EXEC1: `exec1` high 2 cycles.
  - With `instr_code`=46 (LUI): no EXEC1 stall.
- `instr_code`=7 (DIV) with `div_done` pulsed 5 cycles after `div_start`.
  - Required: single `div_start` pulse; `exec2` exactly 1 cycle after `div_done`.
  - `div_done` held high on the first DIV_WAIT cycle is ignored.
- DIVU with no `div_done`, `DIV_MAX_CYCLES`=8.
  - Required: after 8 DIV_WAIT cycles, `active`=0 and `fault`=1; counters frozen thereafter.
  - Variant: `div_done` on the 8th DIV_WAIT cycle → EXEC2, `fault`=0.
- `halt_req`=1 during EXEC2.
  - Required: HALT next cycle with `active`=0, all strobes 0, and `instr_count` including the halting instruction.
  - `halt_req`=1 during FETCH/EXEC1 is ignored.
- Reset asserted mid-DIV_WAIT and asynchronously between clock edges.
  - Required: outputs take reset values immediately; `fetch`=1 on the first cycle after release.

Source files
------------

// File: rtl/cpu_state_ctrl.sv
// Multicycle fetch/exec1/exec2 sequencer for the MIPS core.
// It stalls on bus waitrequest and on the divider, halts on the end-of-program jump and keeps cycle/retire counters.
module cpu_state_ctrl #(
    parameter int DIV_MAX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [6:0]  instr_code,
    input  logic        div_done,
    input  logic        halt_req,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic        div_start,
    output logic        active,
    output logic        fault,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_EXEC1, S_DIV_WAIT, S_EXEC2, S_HALT
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV_MAX_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        is_div, is_mem;

    assign is_div = (instr_code == 7'd7) || (instr_code == 7'd8);
    // LUI (46) sits inside the load/store code range but never touches the bus.
    assign is_mem = instr_code inside {7'd42, 7'd43, 7'd44, 7'd45, 7'd47,
                                       7'd48, 7'd49, 7'd50, 7'd51, 7'd52};

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        fault_d       = fault_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (state_q != S_HALT) cycle_count_d = cycle_count_q + 32'd1;
        case (state_q)
            S_FETCH: begin
                if (!waitrequest) state_d = S_EXEC1;
            end
            S_EXEC1: begin
                if (is_div) begin
                    state_d   = S_DIV_WAIT;
                    div_cnt_d = 8'd0;
                end else if (!(is_mem && waitrequest)) begin
                    state_d = S_EXEC2;
                end
            end
            S_DIV_WAIT: begin
                div_cnt_d = div_cnt_q + 8'd1;
                // div_done on the start cycle is stale from a previous divide.
                if (div_done && (div_cnt_q != 8'd0)) begin
                    state_d = S_EXEC2;
                end else if (div_cnt_q == DIV_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_EXEC2: begin
                instr_count_d = instr_count_q + 32'd1;
                state_d       = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            div_cnt_q     <= 8'd0;
            fault_q       <= 1'b0;
            cycle_count_q <= 32'd0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            fault_q       <= fault_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign fetch       = (state_q == S_FETCH);
    assign exec1       = (state_q == S_EXEC1);
    assign exec2       = (state_q == S_EXEC2);
    assign div_start   = (state_q == S_DIV_WAIT) && (div_cnt_q == 8'd0);
    assign active      = (state_q != S_HALT);
    assign fault       = fault_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_state_ctrl.sv
// Scoreboard bench for cpu_state_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_cpu_state_ctrl;

    localparam int P_F = 0, P_E1 = 1, P_D = 2, P_E2 = 3, P_H = 4;

    typedef struct packed {
        logic        f;
        logic        e1;
        logic        e2;
        logic        ds;
        logic        act;
        logic        flt;
        logic [31:0] cyc;
        logic [31:0] ins;
    } obs_t;

    logic        clk, reset, waitrequest, div_done, halt_req;
    logic [6:0]  instr_code;
    logic        fetch, exec1, exec2, div_start, active, fault;
    logic [31:0] cycle_count, instr_count;

    obs_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;
    logic [31:0] ecyc, eins;
    logic        eflt;

    cpu_state_ctrl #(.DIV_MAX_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest),
        .instr_code(instr_code), .div_done(div_done), .halt_req(halt_req),
        .fetch(fetch), .exec1(exec1), .exec2(exec2), .div_start(div_start),
        .active(active), .fault(fault),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{fetch, exec1, exec2, div_start, active, fault, cycle_count, instr_count};
            nvec++;
            if (a !== e) begin
                nmis++;
                $display("FAIL vec%0d f/e1/e2/ds/act/flt/cyc/ins got %b%b%b%b%b%b %0d %0d want %b%b%b%b%b%b %0d %0d",
                         nvec, a.f, a.e1, a.e2, a.ds, a.act, a.flt, a.cyc, a.ins,
                         e.f, e.e1, e.e2, e.ds, e.act, e.flt, e.cyc, e.ins);
            end
        end
    end

    // One cycle: drive inputs, expect the given phase for this cycle.
    task automatic step(input logic wr, input logic [6:0] code, input logic dd,
                        input logic hr, input int ph, input logic ds);
        obs_t o;
        waitrequest = wr; instr_code = code; div_done = dd; halt_req = hr;
        o = '{(ph == P_F), (ph == P_E1), (ph == P_E2), ds, (ph != P_H), eflt, ecyc, eins};
        exp_q.push_back(o);
        if (ph != P_H) ecyc = ecyc + 32'd1;
        if (ph == P_E2) eins = eins + 32'd1;
        @(posedge clk); #1;
    endtask

    // Reset asserted dly ns after the current point; held through one clock edge.
    task automatic apply_reset(input int dly);
        #dly;
        reset = 1'b1;
        waitrequest = 1'b0; instr_code = 7'd0; div_done = 1'b0; halt_req = 1'b0;
        ecyc = 32'd0; eins = 32'd0; eflt = 1'b0;
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0});
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; waitrequest = 1'b0; instr_code = 7'd0; div_done = 1'b0; halt_req = 1'b0;
        ecyc = 32'd0; eins = 32'd0; eflt = 1'b0;
        @(posedge clk); #1;
        apply_reset(0);

        // Unstalled ADDU stream: period 3, then cyc=9 ins=3 on the 10th cycle.
        for (int i = 0; i < 3; i++) begin
            step(0, 7'd4, 0, 0, P_F,  0);
            step(0, 7'd4, 0, 0, P_E1, 0);
            step(0, 7'd4, 0, 0, P_E2, 0);
        end
        // Fetch stalled 2 cycles.
        step(1, 7'd4, 0, 0, P_F,  0);
        step(1, 7'd4, 0, 0, P_F,  0);
        step(0, 7'd4, 0, 0, P_F,  0);
        step(0, 7'd4, 0, 0, P_E1, 0);
        step(1, 7'd4, 0, 0, P_E2, 0);
        // LW stalled one cycle in EXEC1.
        step(0, 7'd47, 0, 0, P_F,  0);
        step(1, 7'd47, 0, 0, P_E1, 0);
        step(0, 7'd47, 0, 0, P_E1, 0);
        step(0, 7'd47, 0, 0, P_E2, 0);
        // LUI ignores waitrequest in EXEC1.
        step(0, 7'd46, 0, 0, P_F,  0);
        step(1, 7'd46, 0, 0, P_E1, 0);
        step(0, 7'd46, 0, 0, P_E2, 0);
        // DIV: divide beats waitrequest; stale div_done on start cycle ignored; done at cnt 5.
        step(0, 7'd7, 0, 0, P_F,  0);
        step(1, 7'd7, 0, 0, P_E1, 0);
        step(0, 7'd7, 1, 0, P_D,  1);
        for (int i = 1; i < 5; i++) step(0, 7'd7, 0, 0, P_D, 0);
        step(0, 7'd7, 1, 0, P_D,  0);
        step(0, 7'd7, 0, 0, P_E2, 0);
        // DIVU timeout after 8 DIV_WAIT cycles; counters frozen in HALT.
        step(0, 7'd8, 0, 0, P_F,  0);
        step(0, 7'd8, 0, 0, P_E1, 0);
        step(0, 7'd8, 0, 0, P_D,  1);
        for (int i = 1; i < 8; i++) step(0, 7'd8, 0, 0, P_D, 0);
        eflt = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 7'd8, 1, 1, P_H, 0);
        apply_reset(1);
        // DIVU with div_done on the 8th DIV_WAIT cycle: completes, no fault.
        step(0, 7'd8, 0, 0, P_F,  0);
        step(0, 7'd8, 0, 0, P_E1, 0);
        step(0, 7'd8, 0, 0, P_D,  1);
        for (int i = 1; i < 7; i++) step(0, 7'd8, 0, 0, P_D, 0);
        step(0, 7'd8, 1, 0, P_D,  0);
        step(0, 7'd8, 0, 0, P_E2, 0);
        // Reset mid-divide, asserted between edges.
        step(0, 7'd7, 0, 0, P_F,  0);
        step(0, 7'd7, 0, 0, P_E1, 0);
        step(0, 7'd7, 0, 0, P_D,  1);
        apply_reset(2);
        step(0, 7'd4, 0, 0, P_F,  0);
        step(0, 7'd4, 0, 0, P_E1, 0);
        step(0, 7'd4, 0, 0, P_E2, 0);
        // halt_req ignored outside EXEC2, halts after it.
        step(0, 7'd4, 0, 1, P_F,  0);
        step(0, 7'd4, 0, 1, P_E1, 0);
        step(0, 7'd4, 0, 1, P_E2, 0);
        step(0, 7'd4, 0, 0, P_H,  0);
        step(1, 7'd7, 1, 1, P_H,  0);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            nvec++; nmis++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish by 50000ns");
        $fatal(1);
    end

endmodule
